// File: rtl/bet_pkg.sv
// Shared definitions for the roulette bet ledger: opcode defaults, ledger
// states and the {color, opcode} entry layout.
package bet_pkg;

  localparam int DEF_OP_W    = 6;
  localparam int DEF_COLOR_W = 3;

  localparam logic [DEF_OP_W-1:0] DEF_NOP_OP  = 6'h3F;
  localparam logic [DEF_OP_W-1:0] DEF_SPIN_OP = 6'h3E;

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_CLEAR  = 2'd2
  } state_t;

  // Colour occupies the MSBs, opcode the LSBs.
  typedef struct packed {
    logic [DEF_COLOR_W-1:0] color;
    logic [DEF_OP_W-1:0]    opcode;
  } bet_entry_t;

endpackage

// File: rtl/bet_ledger_if.sv
// Keyboard-side bet inputs and regfile-side ledger outputs of bet_ledger.
// master drives keyboard/spin/readout requests; slave is the ledger itself.
interface bet_ledger_if
  import bet_pkg::*;
#(
  parameter int MAX_BETS = 12,
  parameter int OP_W     = DEF_OP_W,
  parameter int COLOR_W  = DEF_COLOR_W
);
  localparam int IDX_W = $clog2(MAX_BETS);
  localparam int CNT_W = $clog2(MAX_BETS + 1);
  localparam int ENT_W = COLOR_W + OP_W;

  logic               kb_valid;
  logic [OP_W-1:0]    kb_opcode;
  logic [COLOR_W-1:0] color;
  logic               spin_done;
  logic               clear;
  logic [IDX_W-1:0]   rd_idx;
  logic [ENT_W-1:0]   rd_data;
  logic [CNT_W-1:0]   bet_count;
  logic               full;
  logic               overflow;
  logic               bet_strobe;
  logic               locked;
  logic               spin_req;

  modport master (
    output kb_valid, kb_opcode, color, spin_done, clear, rd_idx,
    input  rd_data, bet_count, full, overflow, bet_strobe, locked, spin_req
  );

  modport slave (
    input  kb_valid, kb_opcode, color, spin_done, clear, rd_idx,
    output rd_data, bet_count, full, overflow, bet_strobe, locked, spin_req
  );

endinterface

// File: rtl/bet_slot_array.sv
// DEPTH x WIDTH ledger storage: one write port, single-cycle synchronous
// clear and a registered read port that returns 0 for out-of-range indices.
module bet_slot_array #(
  parameter int DEPTH = 12,
  parameter int WIDTH = 9,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] slots [DEPTH];

  // NOTE: the ledger is small and must be emptied in a single cycle, so it is
  // built from resettable flops rather than a RAM macro that cannot be cleared.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (we) begin
      // NOTE: non-blocking so the read port below sees the pre-write contents.
      slots[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else if (int'(rd_idx) < DEPTH) begin
      rd_data <= slots[rd_idx];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/bet_ledger.sv
// Roulette bet ledger: captures qualified keyboard bets into MAX_BETS slots,
// locks during a spin and clears on completion. Optional keypress/release
// pair filter is enabled with BET_LEDGER_PAIR_FILTER_EN.
module bet_ledger
  import bet_pkg::*;
#(
  parameter int               MAX_BETS = 12,
  parameter int               OP_W     = DEF_OP_W,
  parameter int               COLOR_W  = DEF_COLOR_W,
  parameter logic [OP_W-1:0]  NOP_OP   = DEF_NOP_OP,
  parameter logic [OP_W-1:0]  SPIN_OP  = DEF_SPIN_OP
) (
  input logic        clock,
  input logic        reset,
  bet_ledger_if.slave bus
);

  localparam int IDX_W = $clog2(MAX_BETS);
  localparam int CNT_W = $clog2(MAX_BETS + 1);
  localparam int ENT_W = COLOR_W + OP_W;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BETS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] bet_count;
  logic [CNT_W-1:0] count_inc;
  logic             full;
  logic             overflow;
  logic             bet_strobe;
  logic             locked;
  logic             spin_req;

  logic             kb_take;
  logic             is_bet;
  logic             is_spin;
  logic             slot_we;
  logic             slot_clr;

`ifdef BET_LEDGER_PAIR_FILTER_EN
  // Every keypress is followed by a release code; only even pulses count.
  logic phase;

  always_ff @(posedge clock) begin
    if (reset) begin
      phase <= 1'b0;
    end else if (bus.clear || state == ST_CLEAR) begin
      phase <= 1'b0;
    end else if (bus.kb_valid) begin
      phase <= ~phase;
    end
  end

  assign kb_take = bus.kb_valid && !phase;
`else
  assign kb_take = bus.kb_valid;
`endif

  // NOP and SPIN are tested separately so neither opcode can be stored.
  assign is_bet  = kb_take && (bus.kb_opcode != NOP_OP) &&
                   (bus.kb_opcode != SPIN_OP) && (bus.color != '0);
  assign is_spin = kb_take && (bus.kb_opcode == SPIN_OP);

  assign count_inc = bet_count + ONE_CNT;
  assign slot_we   = (state == ST_OPEN) && !bus.clear && is_bet && !full;
  assign slot_clr  = bus.clear || (state == ST_CLEAR) ||
                     ((state == ST_LOCKED) && bus.spin_done);

  bet_slot_array #(
    .DEPTH (MAX_BETS),
    .WIDTH (ENT_W),
    .IDX_W (IDX_W)
  ) u_slots (
    .clock   (clock),
    .reset   (reset),
    .clr     (slot_clr),
    .we      (slot_we),
    .wr_idx  (bet_count[IDX_W-1:0]),
    .wr_data ({bus.color, bus.kb_opcode}),
    .rd_idx  (bus.rd_idx),
    .rd_data (bus.rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_OPEN;
      bet_count  <= '0;
      full       <= 1'b0;
      overflow   <= 1'b0;
      bet_strobe <= 1'b0;
      locked     <= 1'b0;
      spin_req   <= 1'b0;
    end else begin
      bet_strobe <= 1'b0;
      spin_req   <= 1'b0;
      if (bus.clear) begin
        state     <= ST_OPEN;
        bet_count <= '0;
        full      <= 1'b0;
        overflow  <= 1'b0;
        locked    <= 1'b0;
      end else begin
        case (state)
          ST_OPEN: begin
            if (is_bet) begin
              if (!full) begin
                bet_count  <= count_inc;
                full       <= (count_inc == MAX_CNT);
                bet_strobe <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end else if (is_spin && bet_count != '0) begin
              state    <= ST_LOCKED;
              locked   <= 1'b1;
              spin_req <= 1'b1;
            end
          end
          ST_LOCKED: begin
            // Count drops as CLEAR is entered; locked holds through CLEAR.
            if (bus.spin_done) begin
              state     <= ST_CLEAR;
              bet_count <= '0;
              full      <= 1'b0;
              overflow  <= 1'b0;
            end
          end
          ST_CLEAR: begin
            state     <= ST_OPEN;
            bet_count <= '0;
            full      <= 1'b0;
            overflow  <= 1'b0;
            locked    <= 1'b0;
          end
          default: begin
            state  <= ST_OPEN;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.bet_count  = bet_count;
  assign bus.full       = full;
  assign bus.overflow   = overflow;
  assign bus.bet_strobe = bet_strobe;
  assign bus.locked     = locked;
  assign bus.spin_req   = spin_req;

endmodule

// File: tb/tb_bet_ledger.sv
// Self-checking bench for bet_ledger: directed scenarios plus randomized
// traffic compared every cycle against a queue-based ledger model.
module tb_bet_ledger;
  import bet_pkg::*;

  localparam int MAX_BETS = 12;
`ifdef BET_LEDGER_PAIR_FILTER_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  localparam logic [5:0] NOP  = DEF_NOP_OP;
  localparam logic [5:0] SPIN = DEF_SPIN_OP;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bet_ledger_if #(.MAX_BETS(MAX_BETS)) bus ();

  bet_ledger #(.MAX_BETS(MAX_BETS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests = 0;
  int failed = 0;
  int strobe_seen = 0;
  int spin_seen = 0;

  // Reference model: the ledger as a queue of entries plus spin status flags.
  bet_entry_t ent[$];
  bit         m_ovf, m_locked, m_clearing, m_strobe, m_spin, m_phase;
  bet_entry_t m_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit take, qual, spin;
    bet_entry_t rd_next;
    take = bus.kb_valid && !(PF && m_phase);
    qual = take && bus.kb_opcode != NOP && bus.kb_opcode != SPIN && bus.color != 3'd0;
    spin = take && bus.kb_opcode == SPIN;
    rd_next = (int'(bus.rd_idx) < ent.size()) ? ent[bus.rd_idx] : '0;
    m_strobe = 1'b0;
    m_spin = 1'b0;
    if (reset) begin
      ent.delete();
      m_ovf = 0; m_locked = 0; m_clearing = 0; m_phase = 0;
      m_rd = '0;
    end else begin
      m_rd = rd_next;
      if (PF) begin
        if (bus.clear || m_clearing) m_phase = 1'b0;
        else if (bus.kb_valid) m_phase = ~m_phase;
      end
      if (bus.clear) begin
        ent.delete();
        m_ovf = 0; m_locked = 0; m_clearing = 0;
      end else if (m_clearing) begin
        m_clearing = 0;
        m_locked = 0;
      end else if (m_locked) begin
        if (bus.spin_done) begin
          ent.delete();
          m_ovf = 0;
          m_clearing = 1;
        end
      end else if (qual) begin
        if (ent.size() < MAX_BETS) begin
          ent.push_back({bus.color, bus.kb_opcode});
          m_strobe = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (spin && ent.size() > 0) begin
        m_locked = 1'b1;
        m_spin = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("bet_count", 32'(bus.bet_count), 32'(ent.size()));
    check("full", 32'(bus.full), 32'(ent.size() == MAX_BETS));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("bet_strobe", 32'(bus.bet_strobe), 32'(m_strobe));
    check("locked", 32'(bus.locked), 32'(m_locked));
    check("spin_req", 32'(bus.spin_req), 32'(m_spin));
    check("rd_data", 32'(bus.rd_data), 32'(m_rd));
    strobe_seen += int'(bus.bet_strobe);
    spin_seen += int'(bus.spin_req);
  endtask

  task automatic idle();
    bus.kb_valid = 1'b0;
    bus.spin_done = 1'b0;
    bus.clear = 1'b0;
    tick();
  endtask

  // One keypress; with the pair filter a release pulse follows it.
  task automatic press(input logic [5:0] op, input logic [2:0] col);
    bus.kb_valid = 1'b1;
    bus.kb_opcode = op;
    bus.color = col;
    tick();
    if (PF) tick();
    bus.kb_valid = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    bus.kb_valid = 0; bus.kb_opcode = '0; bus.color = '0;
    bus.spin_done = 0; bus.clear = 0; bus.rd_idx = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("reset_count", 32'(bus.bet_count), 0);
    check("reset_locked", 32'(bus.locked), 0);

    // Three bets and a readout.
    strobe_seen = 0;
    press(6'd5, 3'd1); press(6'd9, 3'd2); press(6'd17, 3'd3);
    bus.rd_idx = 4'd1;
    idle();
    check("three_count", 32'(bus.bet_count), 3);
    check("three_rd1", 32'(bus.rd_data), 32'({3'd2, 6'd9}));
    check("three_strobes", 32'(strobe_seen), 3);

    // Non-qualifying pulses on an empty ledger.
    do_clear();
    spin_seen = 0;
    press(NOP, 3'd1); press(6'd6, 3'd0); press(SPIN, 3'd4);
    idle();
    check("nq_count", 32'(bus.bet_count), 0);
    check("nq_spin", 32'(spin_seen), 0);
    check("nq_locked", 32'(bus.locked), 0);

    // Fill to capacity and overflow.
    do_clear();
    for (int i = 0; i < 13; i++) begin
      press(6'(i + 1), 3'((i % 7) + 1));
      if (i == 11) check("full_12", 32'(bus.full), 1);
    end
    bus.rd_idx = 4'd11;
    idle();
    check("ovf_count", 32'(bus.bet_count), 12);
    check("ovf_flag", 32'(bus.overflow), 1);
    check("slot11", 32'(bus.rd_data), 32'({3'd5, 6'd12}));
    bus.rd_idx = 4'd13;
    idle();
    check("oor_rd", 32'(bus.rd_data), 0);

    // Spin cycle.
    do_clear();
    press(6'd3, 3'd1); press(6'd4, 3'd2);
    spin_seen = 0;
    bus.kb_valid = 1'b1; bus.kb_opcode = SPIN; bus.color = 3'd1;
    tick();
    check("spin_pulse", 32'(bus.spin_req), 1);
    check("spin_locked", 32'(bus.locked), 1);
    if (PF) tick();
    idle();
    check("spin_once", 32'(spin_seen), 1);
    press(6'd7, 3'd3);
    check("locked_ignore", 32'(bus.bet_count), 2);
    bus.spin_done = 1'b1;
    tick();
    bus.spin_done = 1'b0;
    check("clear_locked", 32'(bus.locked), 1);
    check("clear_count", 32'(bus.bet_count), 0);
    idle();
    check("open_locked", 32'(bus.locked), 0);
    check("open_ovf", 32'(bus.overflow), 0);
    press(6'd8, 3'd4);
    check("reopen_bet", 32'(bus.bet_count), 1);

    // clear wins over a same-cycle bet.
    bus.clear = 1'b1; bus.kb_valid = 1'b1; bus.kb_opcode = 6'd5; bus.color = 3'd1;
    tick();
    idle(); idle();
    check("clear_prio", 32'(bus.bet_count), 0);

    // Reset while locked.
    press(6'd1, 3'd1); press(SPIN, 3'd1);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_count", 32'(bus.bet_count), 0);
    check("rst_spin", 32'(bus.spin_req), 0);

    // Press/release pairs.
    do_clear();
    for (int i = 0; i < 4; i++) begin
      bus.kb_valid = 1'b1; bus.kb_opcode = 6'd10; bus.color = 3'd2;
      tick(); tick();
    end
    idle();
    check("pairs", 32'(bus.bet_count), PF ? 4 : 8);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      int sel;
      bus.kb_valid = ($urandom_range(0, 1) == 1);
      sel = int'($urandom_range(0, 9));
      bus.kb_opcode = (sel == 0) ? NOP : (sel == 1) ? SPIN : 6'($urandom_range(0, 63));
      bus.color = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      bus.spin_done = ($urandom_range(0, 19) == 0);
      bus.clear = ($urandom_range(0, 149) == 0);
      bus.rd_idx = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
